// File: rtl/module_serial_sub_8bits.sv
// module_serial_sub_8bits: bit-serial a - b, LSB first, with start/ready/done handshake
module module_serial_sub_8bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic [WIDTH-1:0] a_pi,
    input  logic [WIDTH-1:0] b_pi,
    input  logic             start_pi,
    output logic             ready_po,
    output logic [WIDTH-1:0] result_po,
    output logic             borrow_po,
    output logic             ovf_po,
    output logic             done_po
);
    localparam logic [1:0] IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    logic [1:0] state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [CW-1:0] cnt;
    logic bin, a_msb, b_msb, d, bout, last;
    assign d = a_sr[0] ^ b_sr[0] ^ bin;
    assign bout = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin);
    assign last = cnt == CW'(WIDTH - 1);
    assign ready_po = state == IDLE;
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            cnt       <= '0;
            bin       <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            result_po <= '0;
            borrow_po <= 1'b0;
            ovf_po    <= 1'b0;
            done_po   <= 1'b0;
        end else begin
            done_po <= 1'b0;
            case (state)
                IDLE: if (start_pi) begin
                    a_sr  <= a_pi;
                    b_sr  <= b_pi;
                    a_msb <= a_pi[WIDTH-1];
                    b_msb <= b_pi[WIDTH-1];
                    bin   <= 1'b0;
                    cnt   <= '0;
                    state <= SUB;
                end
                SUB: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {d, r_sr[WIDTH-1:1]};
                    bin   <= bout;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    state <= last ? DONE : SUB;
                end
                DONE: begin
                    result_po <= r_sr;
                    borrow_po <= bin;
                    ovf_po    <= (a_msb != b_msb) && (r_sr[WIDTH-1] != a_msb);
                    done_po   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
